dmem_slave: RTL and testbench
=============================

Name: dmem_slave

Overview:
Data-memory responder on the MEM-stage RAM interface (ce/we/addr/sel/data), i.e. the RAM end of that bus. The block is a word-organised, byte-lane-writable data store with a configurable access latency. While a request is outstanding it drives stall_req, and the pipeline holds the request stable until the access completes. Lane order is big-endian: sel[3] selects bits 31:24 and sel[0] selects bits 7:0.

Parameters:
ADDR_WIDTH, 10, number of word-address bits (depth = 2**ADDR_WIDTH words); the word index is addr[ADDR_WIDTH+1:2].
WAIT_CYCLES, 2, extra wait states inserted before the access is performed (0..15).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; synchronous, active-high
ce_i  in  1  chip enable; request valid
we_i  in  1  1 = write, 0 = read
addr_i  in  32  byte address; bits [1:0] ignored
sel_i  in  4  byte-lane select; sel_i[3] = bits 31:24
data_i  in  32  write data, already lane-replicated by the initiator
data_o  out  32  read data, always a full word
ready_o  out  1  access complete; high for exactly one cycle
stall_req_o  out  1  pipeline hold request

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, data_o=0, ready_o=0. The memory array is not cleared.
- stall_req_o = ce_i && (state != DONE). Combinational; 0 during reset.
- State machine:
  - IDLE: on ce_i=1, capture addr/we/sel/data into request regs, load cnt=WAIT_CYCLES, go BUSY.
  - BUSY, ce_i=1, cnt!=0: cnt decrements.
  - BUSY, ce_i=1, cnt==0: perform the access from the captured regs and go DONE.
    - Write: update only the lanes with sel=1; other lanes are unchanged; data_o is unchanged.
    - Read: data_o <= mem[word]; sel is ignored on reads.
  - BUSY, ce_i=0: abort (flush). Go IDLE; no write occurs; data_o is unchanged.
  - DONE: ready_o=1 and stall_req_o=0. Next edge goes to IDLE unconditionally.
  - The initiator presenting a new request during DONE is not captured. It is captured in the following IDLE cycle; stall is reasserted there.
- Latency: with the request first seen in IDLE at cycle 0, DONE occurs at cycle WAIT_CYCLES+2, and stall_req_o is high for WAIT_CYCLES+2 cycles.
- Request inputs changing during BUSY are ignored; the captured copy is used.
- sel_i=0 on a write: completes normally with no memory change.
- data_o holds its value outside DONE.
- Address bits above ADDR_WIDTH+1 are ignored (aliasing), unless the optional feature below is compiled in.
- rst asserted mid-operation: return to IDLE; any pending write is dropped.

Optional Feature:
DMEM_RANGE_CHK_EN
- Defined:
  - Adds port err_o (out, 1), reset 0.
  - A request with any of addr_i[31:ADDR_WIDTH+2] nonzero still walks the full FSM but performs no write.
  - For such a request, DONE drives data_o=0 and err_o=1 for that one cycle; err_o is 0 otherwise.
- Undefined: no err_o port; upper address bits alias.

Decomposition:
- Shared defines: RegBus width, ChipEnable/ChipDisable, WriteEnable/WriteDisable, and the DMEM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module: dmem_byte_bank, instantiated 4×.
  - One 8-bit × 2**ADDR_WIDTH array per lane.
  - Ports: clk, we, addr, din[7:0], dout[7:0].
  - The top level gates each bank's we with sel[k] and the access strobe.

Test Plan:
- Full-word write then read, WAIT_CYCLES=2.
  - Stimulus: write addr=0x10, sel=1111, data=0xDEADBEEF; then read addr=0x10.
  - Required: stall_req high 4 cycles per access; ready_o pulses once per access; read returns data_o=0xDEADBEEF.
- Byte-lane write.
  - Stimulus: preload 0x11223344 at addr=0x20; write sel=0100, data=0xAAAAAAAA; read back.
  - Required: data_o=0x11AA3344.
- Abort.
  - Stimulus: write 0xFFFFFFFF to addr=0x30 and drop ce_i during BUSY; then read addr=0x30.
  - Required: prior contents returned; no ready_o pulse for the aborted request.
- Reset mid-operation.
  - Stimulus: assert rst during BUSY of a write.
  - Required: next cycle state=IDLE, ready_o=0, data_o=0; memory word unchanged.
- WAIT_CYCLES=0 back-to-back.
  - Stimulus: two reads held on the bus.
  - Required: each completes in 2 cycles; one idle cycle separates the ready_o pulses.
- DMEM_RANGE_CHK_EN, ADDR_WIDTH=10.
  - Stimulus: write to addr=0x00001000.
  - Required: err_o=1 in DONE, data_o=0, word 0 unchanged.

Source files
------------

// File: rtl/dmem_slave_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: bus widths,
// enable encodings, FSM state encoding and the captured request payload.
package dmem_slave_pkg;

    localparam int unsigned REG_BUS_W = 32;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned CNT_W     = 4;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // Request fields held stable for the whole access
    typedef struct packed {
        logic                 we;
        logic [SEL_W-1:0]     sel;
        logic                 oob;
        logic [REG_BUS_W-1:0] data;
    } dmem_req_t;

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data store: synchronous write, asynchronous read.
module dmem_byte_bank #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout
);

    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Lane write; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/dmem_slave.sv
// Data-memory responder for the MEM-stage RAM bus. Word-organised store with
// big-endian byte-lane writes and WAIT_CYCLES wait states per access.
// Optional build macro DMEM_RANGE_CHK_EN adds err_o and suppresses writes to
// addresses beyond the array instead of letting them alias.
module dmem_slave
    import dmem_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_i,
    input  logic                 we_i,
    input  logic [REG_BUS_W-1:0] addr_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [REG_BUS_W-1:0] data_i,
    output logic [REG_BUS_W-1:0] data_o,
    output logic                 ready_o,
    output logic                 stall_req_o
`ifdef DMEM_RANGE_CHK_EN
    ,
    output logic                 err_o
`endif
);

    dmem_state_e           state;
    dmem_state_e           state_nxt;
    logic [CNT_W-1:0]      cnt;
    dmem_req_t             req;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  capture;
    logic                  access;
    logic [SEL_W-1:0]      lane_we;
    logic [REG_BUS_W-1:0]  rd_word;
    logic                  addr_oob;
    logic                  unused_addr_bits;

    // Byte offset is never used; upper bits only matter with range checking
    assign unused_addr_bits = ^{addr_i[REG_BUS_W-1:ADDR_WIDTH+2], addr_i[1:0]};

`ifdef DMEM_RANGE_CHK_EN
    assign addr_oob = |addr_i[REG_BUS_W-1:ADDR_WIDTH+2];
`else
    assign addr_oob = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DMEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping ce_i while busy flushes the request
    always_comb begin
        state_nxt = state;
        unique case (state)
            DMEM_IDLE: if (ce_i == CHIP_ENABLE) state_nxt = DMEM_BUSY;
            DMEM_BUSY: begin
                if (ce_i == CHIP_DISABLE) begin
                    state_nxt = DMEM_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = DMEM_DONE;
                end
            end
            DMEM_DONE: state_nxt = DMEM_IDLE;
            default:   state_nxt = DMEM_IDLE;
        endcase
    end

    // Output and strobe decode from the current state
    always_comb begin
        ready_o     = 1'b0;
        stall_req_o = 1'b0;
        capture     = 1'b0;
        access      = 1'b0;
        lane_we     = '0;
        ready_o     = (state == DMEM_DONE);
        stall_req_o = ce_i && !rst && (state != DMEM_DONE);
        capture     = (state == DMEM_IDLE) && (ce_i == CHIP_ENABLE);
        access      = (state == DMEM_BUSY) && (ce_i == CHIP_ENABLE) && (cnt == '0) && !rst;
        if (access && (req.we == WRITE_ENABLE) && !req.oob) begin
            lane_we = req.sel;
        end
    end

    // Wait-state counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (capture) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if ((state == DMEM_BUSY) && (ce_i == CHIP_ENABLE) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Request capture; later bus changes are ignored until the next IDLE
    always_ff @(posedge clk) begin
        if (capture) begin
            req.we   <= we_i;
            req.sel  <= sel_i;
            req.oob  <= addr_oob;
            req.data <= data_i;
            req_word <= addr_i[ADDR_WIDTH+1:2];
        end
    end

    // Read data register: loaded only on a completing read, zeroed on a range error
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (access && req.oob) begin
            data_o <= '0;
        end else if (access && (req.we == WRITE_DISABLE)) begin
            data_o <= rd_word;
        end
    end

`ifdef DMEM_RANGE_CHK_EN
    // Error flag lines up with the DONE cycle of an out-of-range request
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= access && req.oob;
        end
    end
`endif

    // Lane k holds bits [8k+7:8k]; sel[3] therefore addresses the MSB lane
    for (genvar k = 0; k < SEL_W; k++) begin : g_lane
        dmem_byte_bank #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk  (clk),
            .we   (lane_we[k]),
            .addr (req_word),
            .din  (req.data[LANE_W*k +: LANE_W]),
            .dout (rd_word[LANE_W*k +: LANE_W])
        );
    end

endmodule

// File: tb/tb_dmem_slave.sv
// Self-checking bench for dmem_slave: directed scenarios plus randomized
// accesses against a word-array reference model.
module tb_dmem_slave;

    localparam int unsigned W0 = 2;

    logic        clk;
    logic        rst;
    logic        ce, we, rdy, stall;
    logic [31:0] addr, din, dout;
    logic [3:0]  sel;
    logic        ce1, we1, rdy1, stall1;
    logic [31:0] addr1, din1, dout1;
    logic [3:0]  sel1;
`ifdef DMEM_RANGE_CHK_EN
    logic        err0, err1;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [1024];
    logic [31:0] last_rd;

    dmem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(din), .data_o(dout), .ready_o(rdy), .stall_req_o(stall)
`ifdef DMEM_RANGE_CHK_EN
        , .err_o(err0)
`endif
    );

    dmem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we1), .addr_i(addr1), .sel_i(sel1),
        .data_i(din1), .data_o(dout1), .ready_o(rdy1), .stall_req_o(stall1)
`ifdef DMEM_RANGE_CHK_EN
        , .err_o(err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) & 32'd1023;
    endfunction

    // One access on dut0 starting in IDLE; abort_at>=0 drops ce after that many busy edges
    task automatic acc0(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at);
        int          cyc;
        int          stall_n;
        bit          aborted;
        bit          seen_rdy;
        bit          is_oob;
        logic [31:0] exp;
        is_oob = 0;
`ifdef DMEM_RANGE_CHK_EN
        is_oob = (a >= 32'h0000_1000);
`endif
        cyc = 0; stall_n = 0; aborted = 0;
        ce = 1; we = w; addr = a; sel = s; din = d;
        while (cyc < 64) begin
            @(negedge clk);
            if (rdy) break;
            if (stall) stall_n++;
            @(posedge clk); #1;
            if (abort_at >= 0 && cyc == abort_at) begin
                ce = 0;
                aborted = 1;
                break;
            end
            cyc++;
            we = 1'($urandom); addr = $urandom; sel = 4'($urandom); din = $urandom;
        end
        if (aborted) begin
            seen_rdy = 0;
            repeat (W0 + 4) begin
                @(negedge clk);
                if (rdy) seen_rdy = 1;
            end
            chk("abort_no_ready", 32'(seen_rdy), 32'd0);
            chk("abort_dout_hold", dout, last_rd);
            @(posedge clk); #1;
            return;
        end
        chk("latency", 32'(cyc), 32'(W0 + 2));
        chk("stall_cycles", 32'(stall_n), 32'(W0 + 2));
        chk("stall_in_done", 32'(stall), 32'd0);
        if (is_oob) exp = 32'd0;
        else if (!w) exp = mdl[widx(a)];
        else exp = last_rd;
        chk(w ? "wr_dout" : "rd_data", dout, exp);
        last_rd = exp;
        if (w && !is_oob) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) mdl[widx(a)][8*k +: 8] = d[8*k +: 8];
            end
        end
`ifdef DMEM_RANGE_CHK_EN
        chk("err_flag", 32'(err0), 32'(is_oob));
`endif
        @(posedge clk); #1;
        ce = 0;
        @(negedge clk);
        chk("ready_once", 32'(rdy), 32'd0);
        chk("dout_hold", dout, last_rd);
`ifdef DMEM_RANGE_CHK_EN
        chk("err_clear", 32'(err0), 32'd0);
`endif
        @(posedge clk); #1;
    endtask

    // Full-word write on dut0 interrupted by reset k edges into BUSY
    task automatic rst_mid(input logic [31:0] a, input int k);
        ce = 1; we = 1; addr = a; sel = 4'hF; din = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        repeat (k) begin
            @(posedge clk); #1;
        end
        rst = 1;
        @(negedge clk);
        chk("stall_in_rst", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 0; ce = 0;
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_dout", dout, 32'd0);
        last_rd = 32'd0;
        @(posedge clk); #1;
    endtask

    // Full-word write on dut1 (no wait states)
    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        int n;
        ce1 = 1; we1 = 1; addr1 = a; sel1 = 4'hF; din1 = d;
        for (n = 0; n < 16; n++) begin
            @(negedge clk);
            if (rdy1) break;
            @(posedge clk); #1;
        end
        chk("wr1_latency", 32'(n), 32'd2);
        @(posedge clk); #1;
        ce1 = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] da, db;
        int          wi;
        int          first, second;

        rst = 1; ce = 1; we = 0; addr = 0; sel = 0; din = 0;
        ce1 = 0; we1 = 0; addr1 = 0; sel1 = 0; din1 = 0;
        last_rd = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", dout, 32'd0);
        chk("reset_ready", 32'(rdy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 0; ce = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) acc0(1, 32'(i * 4), 4'hF, $urandom, -1);

        acc0(1, 32'h10, 4'hF, 32'hDEAD_BEEF, -1);
        acc0(0, 32'h10, 4'hF, 32'h0, -1);
        chk("full_word_rd", dout, 32'hDEAD_BEEF);

        acc0(1, 32'h20, 4'hF, 32'h1122_3344, -1);
        acc0(1, 32'h20, 4'b0100, 32'hAAAA_AAAA, -1);
        acc0(0, 32'h20, 4'h0, 32'h0, -1);
        chk("lane_write", dout, 32'h11AA_3344);

        acc0(1, 32'h30, 4'hF, 32'h5A5A_1234, -1);
        acc0(1, 32'h30, 4'hF, 32'hFFFF_FFFF, 1);
        acc0(0, 32'h30, 4'hF, 32'h0, -1);
        chk("abort_keep", dout, 32'h5A5A_1234);

        rst_mid(32'h30, 2);
        rst_mid(32'h30, int'($urandom_range(0, 1)));
        acc0(0, 32'h30, 4'hF, 32'h0, -1);
        chk("rst_keep", dout, 32'h5A5A_1234);

        acc0(1, 32'h10, 4'h0, 32'h1234_5678, -1);
        acc0(0, 32'h10, 4'hF, 32'h0, -1);
        chk("sel_zero_wr", dout, 32'hDEAD_BEEF);

`ifdef DMEM_RANGE_CHK_EN
        da = mdl[0];
        acc0(1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, -1);
        acc0(0, 32'h0, 4'hF, 32'h0, -1);
        chk("oob_word0_kept", dout, da);
`else
        acc0(1, 32'h0000_1010, 4'hF, 32'h0BAD_CAFE, -1);
        acc0(0, 32'h10, 4'hF, 32'h0, -1);
        chk("alias_wr", dout, 32'h0BAD_CAFE);
`endif

        for (int i = 0; i < 40; i++) begin
            r  = $urandom;
            wi = int'($urandom_range(0, 15));
            a  = (r & 32'hFFFF_F000) | 32'(wi << 2) | (r & 32'h3);
`ifdef DMEM_RANGE_CHK_EN
            if ($urandom_range(0, 3) != 0) a = a & 32'h0000_0FFF;
`endif
            acc0(1'($urandom), a, 4'($urandom), $urandom,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W0)) : -1);
        end

        da = $urandom; db = $urandom;
        wr1(32'h40, da);
        wr1(32'h44, db);
        first = -1; second = -1;
        ce1 = 1; we1 = 0; addr1 = 32'h40; sel1 = 4'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy1) begin
                if (first < 0) begin
                    first = c;
                    chk("b2b_rd_a", dout1, da);
                    chk("b2b_stall_done", 32'(stall1), 32'd0);
                end else if (second < 0) begin
                    second = c;
                    chk("b2b_rd_b", dout1, db);
                end
            end
            if (c == 3) chk("b2b_stall_reassert", 32'(stall1), 32'd1);
            @(posedge clk); #1;
            if (c == first) addr1 = 32'h44;
            if (c == second) ce1 = 0;
        end
        chk("b2b_first_ready", 32'(first), 32'd2);
        chk("b2b_second_ready", 32'(second), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
